// File: rtl/keypad_entry.sv
// Debounced key-entry controller for a 16-button keypad scanner.
// Accepts one key per physical press and shifts it into a two-digit display history.
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] button,
  output logic [7:0] digits,
  output logic [3:0] key,
  output logic       new_press,
  output logic       held
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [4:0]       NO_KEY   = 5'h10;

  state_t           state_q;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       digits_q;
  logic [3:0]       key_q;
  logic             new_press_q;
  logic             held_q;

  // held is assigned alongside each transition so it reflects the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cand_q      <= 4'h0;
      cnt_q       <= '0;
      digits_q    <= 8'h00;
      key_q       <= 4'h0;
      new_press_q <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      new_press_q <= 1'b0;
      case (state_q)
        IDLE: begin
          held_q <= 1'b0;
          if (!button[4]) begin
            cand_q  <= button[3:0];
            cnt_q   <= '0;
            state_q <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          held_q <= 1'b0;
          if (button != {1'b0, cand_q}) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= HELD;
            digits_q    <= {digits_q[3:0], cand_q};
            key_q       <= cand_q;
            new_press_q <= 1'b1;
            held_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          held_q <= 1'b1;
          if (button == NO_KEY) begin
            cnt_q   <= '0;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          // Any key seen here is contact bounce on release, not a new entry
          if (!button[4]) begin
            state_q <= HELD;
            held_q  <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            held_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + CNT_ONE;
            held_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign digits    = digits_q;
  assign key       = key_q;
  assign new_press = new_press_q;
  assign held      = held_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry with DEBOUNCE_CYCLES=4: stimulus pushes expected
// {key,digits} entries, a negedge monitor pops one on every new_press pulse.
module tb_keypad_entry;

  logic       clk;
  logic       reset;
  logic [4:0] button;
  logic [7:0] digits;
  logic [3:0] key;
  logic       new_press;
  logic       held;

  int total = 0;
  int bad   = 0;

  logic [11:0] expQ[$];
  logic        prevNp;

  keypad_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .button   (button),
    .digits   (digits),
    .key      (key),
    .new_press(new_press),
    .held     (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive a code and advance n clock edges, leaving us 1 time unit after the last edge
  task automatic applyStimulus(input logic [4:0] code, input int n);
    button = code;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pressAccept(input logic [3:0] k, input logic [7:0] expDigits);
    applyStimulus({1'b0, k}, 4);
    checkOutput("np_before_window", {31'd0, new_press}, 32'd0);
    expQ.push_back({k, expDigits});
    applyStimulus({1'b0, k}, 1);
    checkOutput("np_at_window", {31'd0, new_press}, 32'd1);
    checkOutput("held_at_accept", {31'd0, held}, 32'd1);
  endtask

  task automatic releaseClean();
    applyStimulus(5'h10, 4);
    checkOutput("held_during_release", {31'd0, held}, 32'd1);
    applyStimulus(5'h10, 1);
    checkOutput("held_after_release", {31'd0, held}, 32'd0);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput(name, {18'd0, digits, key, new_press, held}, 32'd0);
  endtask

  // Monitor: every new_press must match the oldest expected entry
  always @(negedge clk) begin
    if (reset) begin
      if (new_press) begin
        checkOutput("np_not_consecutive", {31'd0, prevNp}, 32'd0);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_new_press", {20'd0, key, digits}, 32'hFFFFFFFF);
        end else begin
          checkOutput("entry_key_digits", {20'd0, key, digits}, {20'd0, expQ.pop_front()});
        end
      end
      prevNp <= new_press;
    end else begin
      prevNp <= 1'b0;
    end
  end

  initial begin
    reset  = 1'b0;
    button = 5'h10;
    prevNp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset_state");
    reset = 1'b1;

    // Reset then idle
    for (int i = 0; i < 20; i++) begin
      applyStimulus(5'h10, 1);
      if (i == 0 || i == 19) checkResetValues("idle_outputs");
    end

    // Clean press and release of 5
    pressAccept(4'h5, 8'h05);
    checkOutput("key_clean", {28'd0, key}, 32'h5);
    checkOutput("digits_clean", {24'd0, digits}, 32'h05);
    applyStimulus(5'h05, 1);
    checkOutput("np_one_cycle", {31'd0, new_press}, 32'd0);
    applyStimulus(5'h05, 4);
    releaseClean();
    applyStimulus(5'h10, 5);

    // Press bounce never reaches the debounce window
    applyStimulus(5'h07, 2);
    applyStimulus(5'h10, 1);
    applyStimulus(5'h07, 2);
    applyStimulus(5'h10, 6);
    checkOutput("digits_press_bounce", {24'd0, digits}, 32'h05);
    checkOutput("held_press_bounce", {31'd0, held}, 32'd0);

    // Accept 7, then release bounce
    pressAccept(4'h7, 8'h57);
    applyStimulus(5'h10, 2);
    applyStimulus(5'h07, 1);
    releaseClean();
    applyStimulus(5'h10, 3);
    checkOutput("digits_release_bounce", {24'd0, digits}, 32'h57);

    // Two-key entry
    pressAccept(4'hA, 8'h7A);
    releaseClean();
    applyStimulus(5'h10, 2);
    pressAccept(4'h3, 8'hA3);
    releaseClean();
    applyStimulus(5'h10, 2);
    checkOutput("digits_two_key", {24'd0, digits}, 32'hA3);
    checkOutput("key_two_key", {28'd0, key}, 32'h3);

    // Rollover from a fresh reset: only key 1 is entered
    reset = 1'b0;
    applyStimulus(5'h10, 2);
    reset = 1'b1;
    applyStimulus(5'h10, 2);
    pressAccept(4'h1, 8'h01);
    applyStimulus(5'h02, 6);
    checkOutput("held_rollover", {31'd0, held}, 32'd1);
    releaseClean();
    applyStimulus(5'h10, 2);
    checkOutput("digits_rollover", {24'd0, digits}, 32'h01);
    checkOutput("key_rollover", {28'd0, key}, 32'h1);

    // Async reset while in DEBOUNCE
    applyStimulus(5'h0C, 2);
    #2;
    reset = 1'b0;
    #1;
    checkResetValues("async_reset_debounce");
    button = 5'h10;
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(5'h10, 8);
    checkResetValues("after_reset_debounce");

    // Build digits=5C, then async reset while HELD
    pressAccept(4'h5, 8'h05);
    releaseClean();
    applyStimulus(5'h10, 2);
    pressAccept(4'hC, 8'h5C);
    applyStimulus(5'h0C, 2);
    checkOutput("digits_before_reset", {24'd0, digits}, 32'h5C);
    #2;
    reset = 1'b0;
    #1;
    checkResetValues("async_reset_held");
    button = 5'h10;
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(5'h10, 8);
    checkResetValues("after_reset_held");

    checkOutput("scoreboard_drained", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
